// File: rtl/add64_seq.sv
// Two-pass sequential adder/subtractor: a 2*HALF_W-bit operation is split into
// a low and a high pass through one external HALF_W-bit combinational adder.
module add64_seq #(
  parameter int HALF_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [2*HALF_W-1:0] op_a_i,
  input  logic [2*HALF_W-1:0] op_b_i,
  input  logic                sub_i,
  output logic [HALF_W-1:0]   add_a_o,
  output logic [HALF_W-1:0]   add_b_o,
  output logic                add_cin_o,
  input  logic [HALF_W-1:0]   add_sum_i,
  input  logic                add_cout_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*HALF_W-1:0] sum_o,
  output logic                cout_o,
  output logic                ovf_o
);

  localparam int W = 2 * HALF_W;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   bx_q;
  logic [W-1:0]   sum_q;
  logic           sub_q;
  logic           carry_q;
  logic           cout_q;
  logic           ovf_q;

  assign in_ready_o  = (state == IDLE) && rst_ni;
  assign out_valid_o = (state == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

  // Adder operands are only driven during the two passes, otherwise quiet.
  always_comb begin
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    case (state)
      LO: begin
        add_a_o   = a_q[HALF_W-1:0];
        add_b_o   = bx_q[HALF_W-1:0];
        add_cin_o = sub_q;
      end
      HI: begin
        add_a_o   = a_q[W-1:HALF_W];
        add_b_o   = bx_q[W-1:HALF_W];
        add_cin_o = carry_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        // Capture: subtract is A + ~B + 1, the +1 enters as the low-pass carry-in.
        IDLE: begin
          if (in_valid_i) begin
            a_q   <= op_a_i;
            bx_q  <= sub_i ? ~op_b_i : op_b_i;
            sub_q <= sub_i;
            state <= LO;
          end
        end
        // Low pass: keep the low sum half and the carry into the high pass.
        LO: begin
          sum_q[HALF_W-1:0] <= add_sum_i;
          carry_q           <= add_cout_i;
          state             <= HI;
        end
        // High pass: finish the sum, carry-out and signed overflow.
        HI: begin
          sum_q[W-1:HALF_W] <= add_sum_i;
          cout_q            <= add_cout_i;
          ovf_q             <= (a_q[W-1] == bx_q[W-1]) && (add_sum_i[HALF_W-1] != a_q[W-1]);
          state             <= DONE;
        end
        // Result held until the consumer takes it.
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// Directed bench for add64_seq with a behavioural HALF_W-bit adder attached
// and a queue of expected results consumed when the block signals DONE.
module tb_add64_seq;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        sub;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  logic [32:0] add_res;
  res_t        exp_q[$];
  int          checks;
  int          errors;

  add64_seq #(.HALF_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .sub_i       (sub),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_cin_o   (add_cin),
    .add_sum_i   (add_sum),
    .add_cout_i  (add_cout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .ovf_o       (ovf)
  );

  assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_sum  = add_res[31:0];
  assign add_cout = add_res[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] bx;
    logic [64:0] full;
    res_t r;
    bx     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bx} + {64'd0, s};
    r.sum  = full[63:0];
    r.cout = full[64];
    r.ovf  = (a[63] == bx[63]) && (full[63] != a[63]);
    return r;
  endfunction

  // Drives one request at a negedge and walks it to DONE, checking latency.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input res_t expv, input string tag);
    exp_q.push_back(expv);
    @(negedge clk);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub  = s;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lo_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_lo_add_a"}, {32'd0, add_a}, {32'd0, a[31:0]});
    @(negedge clk);
    chk({tag, "_hi_valid"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_done_valid"}, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic compare_out(input string tag);
    res_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_sum"},  sum, e.sum);
      chk({tag, "_cout"}, {63'd0, cout}, {63'd0, e.cout});
      chk({tag, "_ovf"},  {63'd0, ovf},  {63'd0, e.ovf});
    end
  endtask

  task automatic handshake(input string tag);
    logic [63:0] held;
    held = sum;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_retain"}, sum, held);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input res_t expv, input string tag);
    start_op(a, b, s, expv, tag);
    compare_out(tag);
    handshake(tag);
  endtask

  initial begin
    logic [63:0] held_sum;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rs;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum",       sum, 64'd0);
    chk("rst_cout_ovf",  {62'd0, cout, ovf}, 64'd0);
    chk("rst_add_a",     {32'd0, add_a}, 64'd0);
    rst_n = 1'b1;

    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
           '{sum: 64'h0000_0001_0000_0000, cout: 1'b0, ovf: 1'b0}, "carry");
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           '{sum: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1}, "ovf");
    run_op(64'd5, 64'd7, 1'b1,
           '{sum: 64'hFFFF_FFFF_FFFF_FFFE, cout: 1'b0, ovf: 1'b0}, "sub57");
    run_op(64'd7, 64'd5, 1'b1,
           '{sum: 64'd2, cout: 1'b1, ovf: 1'b0}, "sub75");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           '{sum: 64'hFFFF_FFFF_FFFF_FFFE, cout: 1'b1, ovf: 1'b0}, "ones");
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1,
           '{sum: 64'h7FFF_FFFF_FFFF_FFFF, cout: 1'b1, ovf: 1'b1}, "subovf");

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, model(ra, rb, rs), $sformatf("rand%0d", i));
    end

    // Backpressure: result must stay put while new requests are presented.
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
             '{sum: 64'h2222_2222_2222_2211, cout: 1'b0, ovf: 1'b0}, "bp");
    compare_out("bp");
    held_sum = sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      sub  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_hold_sum",   sum, held_sum);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready",   {63'd0, in_ready},  64'd0);
      chk("bp_hold_flags", {62'd0, cout, ovf}, 64'd0);
    end
    in_valid = 1'b0;
    handshake("bp");

    // Reset during the high pass discards the operation.
    exp_q.push_back('{sum: 64'd0, cout: 1'b0, ovf: 1'b0});
    void'(exp_q.pop_back());
    @(negedge clk);
    in_valid = 1'b1;
    op_a = 64'h0000_0000_FFFF_FFFF;
    op_b = 64'd1;
    sub  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rhi_in_hi_cin", {63'd0, add_cin}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rhi_valid",    {63'd0, out_valid}, 64'd0);
    chk("rhi_sum",      sum, 64'd0);
    chk("rhi_add",      {add_a, add_b}, 64'd0);
    chk("rhi_cin",      {63'd0, add_cin}, 64'd0);
    chk("rhi_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rhi_release_ready", {63'd0, in_ready}, 64'd1);
    chk("rhi_still_idle",    {63'd0, out_valid}, 64'd0);
    run_op(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0,
           '{sum: 64'd7, cout: 1'b0, ovf: 1'b0}, "fresh");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
